// File: rtl/dcache_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_pkg : shared types, default geometry and byte-merge helper for the
//              store-buffer write responder.          Rev 1.0
// ---------------------------------------------------------------------------
package dcache_pkg;

  localparam int DC_ADDR_W     = 32;
  localparam int DC_DATA_W     = 32;
  localparam int DC_LINE_WORDS = 4;
  localparam int DC_NUM_SETS   = 16;

  localparam int BYTE_OFF_W = $clog2(DC_DATA_W / 8);
  localparam int WORD_OFF_W = $clog2(DC_LINE_WORDS);
  localparam int INDEX_W    = $clog2(DC_NUM_SETS);
  localparam int TAG_W      = DC_ADDR_W - INDEX_W - WORD_OFF_W - BYTE_OFF_W;
  localparam int LINE_W     = DC_LINE_WORDS * DC_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_REFILL    = 3'd3,
    ST_ACK       = 3'd4
  } state_e;

  function automatic logic [DC_DATA_W-1:0] byte_merge(
    input logic [DC_DATA_W-1:0]   old_word,
    input logic [DC_DATA_W-1:0]   new_word,
    input logic [DC_DATA_W/8-1:0] sel
  );
    logic [DC_DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < DC_DATA_W / 8; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_tag_data_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_tag_data_array : direct-mapped valid/dirty/tag/line storage with
//                         combinational read and synchronous write.   Rev 1.0
// ---------------------------------------------------------------------------
module dcache_tag_data_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS  = DC_NUM_SETS,
  parameter int IDX_W     = INDEX_W,
  parameter int TAG_BITS  = TAG_W,
  parameter int LINE_BITS = LINE_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     idx_i,
  output logic                 valid_o,
  output logic                 dirty_o,
  output logic [TAG_BITS-1:0]  tag_o,
  output logic [LINE_BITS-1:0] line_o,
  input  logic                 we_i,
  input  logic [TAG_BITS-1:0]  wtag_i,
  input  logic [LINE_BITS-1:0] wline_i
);

  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] line_q [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = line_q[idx_i];

  // Every write is either a store hit or a store-merged refill, so it always
  // leaves the line valid and dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[idx_i]  <= wtag_i;
      line_q[idx_i] <= wline_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_stb_write_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_stb_write_responder : write-back/write-allocate D-cache responder
//   for drained stores. Optional counters: DCACHE_STB_PERF_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module dcache_stb_write_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stb2dcache_req,
  input  logic                         stb2dcache_w_en,
  input  logic [ADDR_W-1:0]            stb2dcache_addr,
  input  logic [DATA_W-1:0]            stb2dcache_wdata,
  input  logic [DATA_W/8-1:0]          stb2dcache_sel,
  output logic                         dcache2stb_ack,
  output logic                         dcache2mem_req,
  output logic                         dcache2mem_wr,
  output logic [ADDR_W-1:0]            dcache2mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] dcache2mem_wdata,
  input  logic                         mem2dcache_ack,
  input  logic [LINE_WORDS*DATA_W-1:0] mem2dcache_rdata
`ifdef DCACHE_STB_PERF_CNT_EN
  ,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt,
  output logic [31:0]                  wb_cnt
`endif
);

  localparam int BO_W = $clog2(DATA_W / 8);
  localparam int WO_W = $clog2(LINE_WORDS);
  localparam int IX_W = $clog2(NUM_SETS);
  localparam int LO_W = WO_W + BO_W;
  localparam int TG_W = ADDR_W - IX_W - LO_W;
  localparam int LN_W = LINE_WORDS * DATA_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] sel_q;

  logic [IX_W-1:0]     w_idx;
  logic [TG_W-1:0]     w_tag;
  logic [WO_W-1:0]     w_word;
  logic                w_unused_byte_off;
  logic                w_accept;
  logic                w_hit;
  logic                w_arr_we;
  logic                arr_valid, arr_dirty;
  logic [TG_W-1:0]     arr_tag;
  logic [LN_W-1:0]     arr_line;
  logic [LN_W-1:0]     w_base_line, w_new_line;
  logic [DATA_W-1:0]   w_old_word, w_merged_word;

  assign w_idx             = addr_q[LO_W +: IX_W];
  assign w_tag             = addr_q[ADDR_W-1 -: TG_W];
  assign w_word            = addr_q[BO_W +: WO_W];
  assign w_unused_byte_off = ^addr_q[BO_W-1:0];
  assign w_accept          = (state_q == ST_IDLE) && stb2dcache_req && stb2dcache_w_en;
  assign w_hit             = arr_valid && (arr_tag == w_tag);

  dcache_tag_data_array #(
    .NUM_SETS  (NUM_SETS),
    .IDX_W     (IX_W),
    .TAG_BITS  (TG_W),
    .LINE_BITS (LN_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .idx_i   (w_idx),
    .valid_o (arr_valid),
    .dirty_o (arr_dirty),
    .tag_o   (arr_tag),
    .line_o  (arr_line),
    .we_i    (w_arr_we),
    .wtag_i  (w_tag),
    .wline_i (w_new_line)
  );

  // The store word is merged into either the resident line (hit) or the
  // incoming refill line, whichever w_base_line selects.
  assign w_old_word = w_base_line[w_word*DATA_W +: DATA_W];

  if (DATA_W == DC_DATA_W) begin : g_merge_pkg
    assign w_merged_word = byte_merge(w_old_word, wdata_q, sel_q);
  end else begin : g_merge_generic
    always_comb begin
      w_merged_word = w_old_word;
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (sel_q[b]) w_merged_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_new_line = w_base_line;
    w_new_line[w_word*DATA_W +: DATA_W] = w_merged_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept) begin
        addr_q  <= stb2dcache_addr;
        wdata_q <= stb2dcache_wdata;
        sel_q   <= stb2dcache_sel;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    w_arr_we    = 1'b0;
    w_base_line = arr_line;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          w_arr_we = 1'b1;
          state_d  = ST_ACK;
        end else if (arr_valid && arr_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        if (mem2dcache_ack) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        w_base_line = mem2dcache_rdata;
        if (mem2dcache_ack) begin
          w_arr_we = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state and the array
  // entry addressed by the latched store, so they hold steady while waiting.
  always_comb begin
    dcache2stb_ack   = (state_q == ST_ACK);
    dcache2mem_req   = 1'b0;
    dcache2mem_wr    = 1'b0;
    dcache2mem_addr  = '0;
    dcache2mem_wdata = '0;
    case (state_q)
      ST_WRITEBACK: begin
        dcache2mem_req   = 1'b1;
        dcache2mem_wr    = 1'b1;
        dcache2mem_addr  = {arr_tag, w_idx, {LO_W{1'b0}}};
        dcache2mem_wdata = arr_line;
      end
      ST_REFILL: begin
        dcache2mem_req  = 1'b1;
        dcache2mem_addr = {addr_q[ADDR_W-1:LO_W], {LO_W{1'b0}}};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (state_q == ST_LOOKUP && w_hit && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == ST_LOOKUP && !w_hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
      if (state_q == ST_WRITEBACK && mem2dcache_ack && wb_cnt_q != '1)
        wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule
`default_nettype wire
